// File: rtl/cce_mem_link_client.sv
// Memory-side endpoint of a wormhole link: reassembles command flits into whole
// memory messages and serializes the in-order memory responses back to each command's source.
module cce_mem_link_client
  #(parameter int flit_width_p          = 64,
    parameter int cord_width_p          = 4,
    parameter int len_width_p           = 4,
    parameter int cid_width_p           = 2,
    parameter int msg_width_p           = 128,
    parameter int num_outstanding_req_p = 8)
  (input  logic                      clk_i,
   input  logic                      reset_i,

   output logic [msg_width_p-1:0]    mem_cmd_o,
   output logic                      mem_cmd_v_o,
   input  logic                      mem_cmd_yumi_i,

   input  logic [msg_width_p-1:0]    mem_resp_i,
   input  logic                      mem_resp_v_i,
   output logic                      mem_resp_ready_o,

   input  logic [flit_width_p+1:0]   cmd_link_i,
   output logic [flit_width_p+1:0]   resp_link_o);

  localparam int len_off_lp       = cord_width_p;
  localparam int dst_cid_off_lp   = cord_width_p + len_width_p;
  localparam int src_cord_off_lp  = dst_cid_off_lp + cid_width_p;
  localparam int src_cid_off_lp   = src_cord_off_lp + cord_width_p;
  localparam int msg_off_lp       = src_cid_off_lp + cid_width_p;
  localparam int pkt_width_lp     = msg_off_lp + msg_width_p;
  localparam int num_flits_lp     = (pkt_width_lp + flit_width_p - 1) / flit_width_p;
  localparam int buf_width_lp     = num_flits_lp * flit_width_p;
  localparam int idx_width_lp     = (num_flits_lp > 1) ? $clog2(num_flits_lp) : 1;
  localparam int route_width_lp   = cord_width_p + cid_width_p;
  localparam int ptr_width_lp     = (num_outstanding_req_p > 1) ? $clog2(num_outstanding_req_p) : 1;
  localparam int fifo_cnt_width_lp = $clog2(num_outstanding_req_p + 1);

  logic                    cmd_flit_v;
  logic [flit_width_p-1:0] cmd_flit_data;
  logic                    resp_flit_ready;

  assign cmd_flit_v      = cmd_link_i[flit_width_p+1];
  assign cmd_flit_data   = cmd_link_i[flit_width_p:1];
  assign resp_flit_ready = cmd_link_i[0];

  // Command reassembly
  logic [buf_width_lp-1:0] rx_buf_r;
  logic [idx_width_lp-1:0] rx_idx_r;
  logic                    rx_full_r;
  logic                    rx_ready;
  logic                    rx_fire;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic [route_width_lp-1:0] fifo_head;
  logic [route_width_lp-1:0] cmd_route;

  assign rx_ready  = ~rx_full_r & ~reset_i;
  assign rx_fire   = cmd_flit_v & rx_ready;

  assign mem_cmd_o   = rx_buf_r[msg_off_lp +: msg_width_p];
  assign mem_cmd_v_o = rx_full_r & ~fifo_full & ~reset_i;
  assign cmd_route   = {rx_buf_r[src_cord_off_lp +: cord_width_p],
                        rx_buf_r[src_cid_off_lp +: cid_width_p]};
  assign fifo_push   = mem_cmd_yumi_i & mem_cmd_v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_buf_r  <= '0;
      rx_idx_r  <= '0;
      rx_full_r <= 1'b0;
    end else if (fifo_push) begin
      rx_full_r <= 1'b0;
      rx_idx_r  <= '0;
    end else if (rx_fire) begin
      for (int i = 0; i < num_flits_lp; i++) begin
        if (rx_idx_r == idx_width_lp'(i))
          rx_buf_r[i*flit_width_p +: flit_width_p] <= cmd_flit_data;
      end
      if (rx_idx_r == idx_width_lp'(num_flits_lp-1)) begin
        rx_full_r <= 1'b1;
        rx_idx_r  <= '0;
      end else begin
        rx_idx_r  <= rx_idx_r + idx_width_lp'(1);
      end
    end
  end

  // Destination header bits and padding of incoming packets carry nothing we need
  logic unused_rx_bits;
  assign unused_rx_bits = ^rx_buf_r;

  // Return-route FIFO: one {src_cord, src_cid} per command awaiting its response
  logic [route_width_lp-1:0]    fifo_mem_r [num_outstanding_req_p];
  logic [ptr_width_lp-1:0]      fifo_wr_ptr_r;
  logic [ptr_width_lp-1:0]      fifo_rd_ptr_r;
  logic [fifo_cnt_width_lp-1:0] fifo_cnt_r;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(num_outstanding_req_p-1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  assign fifo_full  = (fifo_cnt_r == fifo_cnt_width_lp'(num_outstanding_req_p));
  assign fifo_empty = (fifo_cnt_r == '0);
  assign fifo_head  = fifo_mem_r[fifo_rd_ptr_r];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fifo_wr_ptr_r <= '0;
      fifo_rd_ptr_r <= '0;
      fifo_cnt_r    <= '0;
    end else begin
      if (fifo_push)
        fifo_wr_ptr_r <= ptr_inc(fifo_wr_ptr_r);
      if (fifo_pop)
        fifo_rd_ptr_r <= ptr_inc(fifo_rd_ptr_r);
      if (fifo_push & ~fifo_pop)
        fifo_cnt_r <= fifo_cnt_r + fifo_cnt_width_lp'(1);
      else if (~fifo_push & fifo_pop)
        fifo_cnt_r <= fifo_cnt_r - fifo_cnt_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push)
      fifo_mem_r[fifo_wr_ptr_r] <= cmd_route;
  end

  // Response serializer
  typedef enum logic {e_idle, e_send} tx_state_e;

  tx_state_e               tx_state_r;
  logic [buf_width_lp-1:0] tx_buf_r;
  logic [idx_width_lp-1:0] tx_idx_r;
  logic [buf_width_lp-1:0] resp_pkt;
  logic                    resp_accept;
  logic                    tx_v;
  logic                    tx_fire;

  assign mem_resp_ready_o = (tx_state_r == e_idle) & ~fifo_empty & ~reset_i;
  assign resp_accept      = mem_resp_v_i & mem_resp_ready_o;
  assign tx_v             = (tx_state_r == e_send) & ~reset_i;
  assign tx_fire          = tx_v & resp_flit_ready;
  assign fifo_pop         = tx_fire & (tx_idx_r == idx_width_lp'(num_flits_lp-1));

  // Source fields stay zero: the memory endpoint has no coordinate of interest to the requester
  always_comb begin
    resp_pkt = '0;
    resp_pkt[0 +: cord_width_p]               = fifo_head[cid_width_p +: cord_width_p];
    resp_pkt[len_off_lp +: len_width_p]       = len_width_p'(num_flits_lp-1);
    resp_pkt[dst_cid_off_lp +: cid_width_p]   = fifo_head[0 +: cid_width_p];
    resp_pkt[msg_off_lp +: msg_width_p]       = mem_resp_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_state_r <= e_idle;
      tx_buf_r   <= '0;
      tx_idx_r   <= '0;
    end else begin
      case (tx_state_r)
        e_idle: begin
          if (resp_accept) begin
            tx_buf_r   <= resp_pkt;
            tx_idx_r   <= '0;
            tx_state_r <= e_send;
          end
        end
        e_send: begin
          if (tx_fire) begin
            tx_buf_r <= tx_buf_r >> flit_width_p;
            if (fifo_pop) begin
              tx_idx_r   <= '0;
              tx_state_r <= e_idle;
            end else begin
              tx_idx_r   <= tx_idx_r + idx_width_lp'(1);
            end
          end
        end
      endcase
    end
  end

  assign resp_link_o = {tx_v, tx_buf_r[flit_width_p-1:0], rx_ready};

endmodule

// File: tb/tb_cce_mem_link_client.sv
// Directed bench for cce_mem_link_client with a two-entry outstanding queue.
module tb_cce_mem_link_client;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [127:0] mem_cmd_o;
  logic         mem_cmd_v_o;
  logic         mem_cmd_yumi_i;
  logic [127:0] mem_resp_i;
  logic         mem_resp_v_i;
  logic         mem_resp_ready_o;
  logic [65:0]  cmd_link_i;
  logic [65:0]  resp_link_o;

  logic        cmd_v;
  logic [63:0] cmd_dat;
  logic        down_rdy;
  logic        resp_v;
  logic [63:0] resp_dat;
  logic        link_rdy;

  int errors = 0;
  int checks = 0;

  assign cmd_link_i = {cmd_v, cmd_dat, down_rdy};
  assign resp_v     = resp_link_o[65];
  assign resp_dat   = resp_link_o[64:1];
  assign link_rdy   = resp_link_o[0];

  always #5 clk_i = ~clk_i;

  cce_mem_link_client #(.num_outstanding_req_p(2)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .mem_cmd_o        (mem_cmd_o),
    .mem_cmd_v_o      (mem_cmd_v_o),
    .mem_cmd_yumi_i   (mem_cmd_yumi_i),
    .mem_resp_i       (mem_resp_i),
    .mem_resp_v_i     (mem_resp_v_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .cmd_link_i       (cmd_link_i),
    .resp_link_o      (resp_link_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] mk_pkt(input logic [3:0] dcord, input logic [3:0] len,
                                          input logic [1:0] dcid, input logic [3:0] scord,
                                          input logic [1:0] scid, input logic [127:0] msg);
    logic [191:0] p;
    p          = '0;
    p[3:0]     = dcord;
    p[7:4]     = len;
    p[9:8]     = dcid;
    p[13:10]   = scord;
    p[15:14]   = scid;
    p[143:16]  = msg;
    return p;
  endfunction

  // All tasks start and end just after a falling edge
  task automatic send_flits(input logic [191:0] pkt, input int n);
    for (int i = 0; i < n; i++) begin
      int waited;
      cmd_v   = 1'b1;
      cmd_dat = pkt[i*64 +: 64];
      waited  = 0;
      while (!link_rdy && waited < 50) begin
        @(negedge clk_i);
        waited++;
      end
      if (!link_rdy) chk("cmd_rdy_timeout", 192'(link_rdy), 192'd1);
      @(posedge clk_i);
      @(negedge clk_i);
    end
    cmd_v = 1'b0;
  endtask

  task automatic issue_cmd(input string tag, input logic [127:0] msg);
    chk({tag, "_v"}, 192'(mem_cmd_v_o), 192'd1);
    chk({tag, "_msg"}, 192'(mem_cmd_o), 192'(msg));
    chk({tag, "_rdy_low"}, 192'(link_rdy), 192'd0);
    mem_cmd_yumi_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    mem_cmd_yumi_i = 1'b0;
    chk({tag, "_rdy_back"}, 192'(link_rdy), 192'd1);
    chk({tag, "_v_drop"}, 192'(mem_cmd_v_o), 192'd0);
  endtask

  task automatic send_resp(input string tag, input logic [127:0] msg);
    chk({tag, "_resp_rdy"}, 192'(mem_resp_ready_o), 192'd1);
    mem_resp_i   = msg;
    mem_resp_v_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    mem_resp_v_i = 1'b0;
    chk({tag, "_resp_rdy_busy"}, 192'(mem_resp_ready_o), 192'd0);
  endtask

  task automatic recv_resp(input string tag, input logic [3:0] dcord, input logic [1:0] dcid,
                           input logic [127:0] msg, input logic [15:0] pat);
    logic [191:0] exp;
    int idx;
    exp = mk_pkt(dcord, 4'd2, dcid, 4'd0, 2'd0, msg);
    idx = 0;
    for (int s = 0; s < 16 && idx < 3; s++) begin
      chk({tag, "_flit_v"}, 192'(resp_v), 192'd1);
      chk({tag, "_flit_dat"}, 192'(resp_dat), 192'(exp[idx*64 +: 64]));
      down_rdy = pat[s];
      @(posedge clk_i);
      if (pat[s]) idx++;
      @(negedge clk_i);
    end
    down_rdy = 1'b0;
    chk({tag, "_done_v"}, 192'(resp_v), 192'd0);
  endtask

  initial begin
    logic [127:0] m0, m1, m2, m3, m4;
    logic [191:0] pkt;
    m0 = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
    m1 = 128'h11111111_22222222_33333333_44444444;
    m2 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    m3 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    m4 = 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D;

    reset_i = 1'b1; cmd_v = 1'b0; cmd_dat = '0; down_rdy = 1'b0;
    mem_cmd_yumi_i = 1'b0; mem_resp_i = '0; mem_resp_v_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_cmd_v", 192'(mem_cmd_v_o), 192'd0);
    chk("rst_resp_v", 192'(resp_v), 192'd0);
    chk("rst_link_rdy", 192'(link_rdy), 192'd0);
    chk("rst_resp_rdy", 192'(mem_resp_ready_o), 192'd0);
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_link_rdy", 192'(link_rdy), 192'd1);
    chk("post_rst_resp_rdy", 192'(mem_resp_ready_o), 192'd0);

    // Single command then its routed response under link backpressure 1,0,0,1,1
    send_flits(mk_pkt(4'h0, 4'd2, 2'd0, 4'h5, 2'h1, m0), 3);
    issue_cmd("single", m0);
    send_resp("route", 128'h1);
    chk("route_f0_dcord", 192'(resp_dat[3:0]), 192'h5);
    chk("route_f0_len", 192'(resp_dat[7:4]), 192'h2);
    chk("route_f0_dcid", 192'(resp_dat[9:8]), 192'h1);
    chk("route_f0_src", 192'(resp_dat[15:10]), 192'h0);
    chk("route_f0_word", 192'(resp_dat), 192'h10125);
    recv_resp("route", 4'h5, 2'h1, 128'h1, 16'b11001);
    chk("route_fifo_empty", 192'(mem_resp_ready_o), 192'd0);

    // Credit limit of two, then in-order return to sources 1, 2, 3
    send_flits(mk_pkt(4'h0, 4'd2, 2'd0, 4'h1, 2'h0, m1), 3);
    issue_cmd("c1", m1);
    send_flits(mk_pkt(4'h0, 4'd2, 2'd0, 4'h2, 2'h3, m2), 3);
    issue_cmd("c2", m2);
    send_flits(mk_pkt(4'h0, 4'd2, 2'd0, 4'h3, 2'h2, m3), 3);
    chk("credit_stall_v", 192'(mem_cmd_v_o), 192'd0);
    chk("credit_stall_rdy", 192'(link_rdy), 192'd0);
    repeat (3) @(negedge clk_i);
    chk("credit_hold_v", 192'(mem_cmd_v_o), 192'd0);
    chk("credit_hold_rdy", 192'(link_rdy), 192'd0);
    send_resp("r1", m4);
    recv_resp("r1", 4'h1, 2'h0, m4, 16'hFFFF);
    issue_cmd("c3", m3);
    send_resp("r2", m2);
    recv_resp("r2", 4'h2, 2'h3, m2, 16'hFFFF);
    send_resp("r3", m1);
    recv_resp("r3", 4'h3, 2'h2, m1, 16'hFFFF);
    chk("order_fifo_empty", 192'(mem_resp_ready_o), 192'd0);

    // Reset after two flits, then a fresh packet must assemble from flit 0
    send_flits(mk_pkt(4'h0, 4'd2, 2'd0, 4'h7, 2'h3, ~m0), 2);
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_link_rdy", 192'(link_rdy), 192'd0);
    chk("mid_rst_cmd_v", 192'(mem_cmd_v_o), 192'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    pkt = mk_pkt(4'h0, 4'd2, 2'd0, 4'h9, 2'h2, m3);
    send_flits(pkt, 2);
    chk("fresh_partial_v", 192'(mem_cmd_v_o), 192'd0);
    chk("fresh_partial_rdy", 192'(link_rdy), 192'd1);
    cmd_v   = 1'b1;
    cmd_dat = pkt[128 +: 64];
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_v = 1'b0;
    issue_cmd("fresh", m3);
    send_resp("fresh", m0);
    recv_resp("fresh", 4'h9, 2'h2, m0, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
